// File: rtl/cmp_pkg.sv
// Shared constants for the registered unsigned magnitude comparator.
// Result encoding is one-hot in {Lesser, Greater, Equal} bit order.
package cmp_pkg;

    localparam int unsigned CMP_DEFAULT_WIDTH = 2;
    localparam int unsigned CMP_DEFAULT_CNT_W = 8;

    localparam logic [2:0] CMP_LT = 3'b100;
    localparam logic [2:0] CMP_GT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

endpackage

// File: rtl/cmp_core.sv
// Purely combinational unsigned compare of two WIDTH-bit operands.
// Produces the one-hot {Lesser, Greater, Equal} result.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = CMP_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       result
);

    // Select exactly one outcome code from the unsigned relation of a and b
    always_comb begin
        result = CMP_EQ;
        if (a < b) begin
            result = CMP_LT;
        end else if (a > b) begin
            result = CMP_GT;
        end
    end

endmodule

// File: rtl/comparator_2bit_sync.sv
// Registered magnitude comparator: one-hot Lesser/Greater/Equal flags appear
// one clock after a valid A/B sample; flags hold while no sample is valid.
// Optional saturating outcome counters are built when
// COMPARATOR_2BIT_STATS_EN is defined.
module comparator_2bit_sync
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = CMP_DEFAULT_WIDTH,
    parameter int unsigned CNT_W = CMP_DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic             Lesser,
    output logic             Greater,
`ifdef COMPARATOR_2BIT_STATS_EN
    output logic             Equal,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt
`else
    output logic             Equal
`endif
);

    logic [2:0] result;

    cmp_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (A),
        .b      (B),
        .result (result)
    );

    // Capture the compare result on valid samples; out_valid marks fresh flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid                 <= 1'b0;
            {Lesser, Greater, Equal}  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                {Lesser, Greater, Equal} <= result;
            end
        end
    end

`ifdef COMPARATOR_2BIT_STATS_EN
    // Saturating per-outcome counters; a clear beats a coincident sample
    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            lt_cnt <= '0;
            gt_cnt <= '0;
            eq_cnt <= '0;
        end else if (in_valid) begin
            if (result == CMP_LT && lt_cnt != '1) begin
                lt_cnt <= lt_cnt + 1'b1;
            end
            if (result == CMP_GT && gt_cnt != '1) begin
                gt_cnt <= gt_cnt + 1'b1;
            end
            if (result == CMP_EQ && eq_cnt != '1) begin
                eq_cnt <= eq_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_comparator_2bit_sync.sv
// Self-checking bench for comparator_2bit_sync: directed vector table,
// exhaustive sweep and random stimulus against a behavioural model.
// Counter checks are built when COMPARATOR_2BIT_STATS_EN is defined.
module tb_comparator_2bit_sync;

    localparam int unsigned W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         Lesser;
    logic         Greater;
    logic         Equal;
`ifdef COMPARATOR_2BIT_STATS_EN
    localparam int unsigned CW = 2;
    logic          stats_clr;
    logic [CW-1:0] lt_cnt;
    logic [CW-1:0] gt_cnt;
    logic [CW-1:0] eq_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state: last reported flags and freshness
    logic       m_valid;
    logic [2:0] m_flags;

    always #5 clk = ~clk;

`ifdef COMPARATOR_2BIT_STATS_EN
    comparator_2bit_sync #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .Lesser    (Lesser),
        .Greater   (Greater),
        .Equal     (Equal),
        .stats_clr (stats_clr),
        .lt_cnt    (lt_cnt),
        .gt_cnt    (gt_cnt),
        .eq_cnt    (eq_cnt)
    );
`else
    comparator_2bit_sync #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .Lesser    (Lesser),
        .Greater   (Greater),
        .Equal     (Equal)
    );
`endif

    typedef struct {
        logic         rst_n;
        logic         in_valid;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   exp;   // {out_valid, Lesser, Greater, Equal}
    } vec_t;

    localparam int NVEC = 13;
    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {v,L,G,E}=%b expected %b", name, got, exp);
        end
    endtask

    task automatic check_cnt(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Drive one cycle (called at negedge), advance to the next negedge, update model
    task automatic apply(input logic r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        rst_n    = r;
        in_valid = v;
        A        = a;
        B        = b;
        @(posedge clk);
        if (!r) begin
            m_valid = 1'b0;
            m_flags = 3'b000;
        end else begin
            m_valid = v;
            if (v) begin
                m_flags = {a < b, a > b, a == b};
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [3:0] dut_out();
        return {out_valid, Lesser, Greater, Equal};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        m_valid  = 1'b0;
        m_flags  = 3'b000;
`ifdef COMPARATOR_2BIT_STATS_EN
        stats_clr = 1'b0;
`endif

        //              rst   vld   A     B     {v,L,G,E}
        tbl[0]  = '{1'b0, 1'b1, 2'd3, 2'd0, 4'b0000}; // reset beats valid
        tbl[1]  = '{1'b0, 1'b1, 2'd3, 2'd0, 4'b0000};
        tbl[2]  = '{1'b1, 1'b1, 2'd3, 2'd0, 4'b1010}; // first result Greater
        tbl[3]  = '{1'b1, 1'b1, 2'd1, 2'd2, 4'b1100};
        tbl[4]  = '{1'b1, 1'b1, 2'd2, 2'd2, 4'b1001};
        tbl[5]  = '{1'b1, 1'b1, 2'd3, 2'd1, 4'b1010};
        tbl[6]  = '{1'b1, 1'b1, 2'd2, 2'd1, 4'b1010};
        tbl[7]  = '{1'b1, 1'b0, 2'd0, 2'd3, 4'b0010}; // hold, valid drops
        tbl[8]  = '{1'b1, 1'b1, 2'd0, 2'd0, 4'b1001};
        tbl[9]  = '{1'b0, 1'b1, 2'd1, 2'd2, 4'b0000}; // mid-stream reset
        tbl[10] = '{1'b1, 1'b0, 2'd1, 2'd2, 4'b0000}; // dropped sample not reported
        tbl[11] = '{1'b1, 1'b1, 2'd3, 2'd3, 4'b1001}; // max == max
        tbl[12] = '{1'b1, 1'b1, 2'd0, 2'd3, 4'b1100}; // min < max

        @(negedge clk);
        apply(1'b0, 1'b0, '0, '0);
        check("reset_state", dut_out(), 4'b0000);

        for (int i = 0; i < NVEC; i++) begin
            apply(tbl[i].rst_n, tbl[i].in_valid, tbl[i].a, tbl[i].b);
            check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
        end

        // X on operands while not valid must not disturb the held flags
        apply(1'b1, 1'b0, 'x, 'x);
        check("x_hold", dut_out(), 4'b0100);
        apply(1'b1, 1'b0, 'x, 'x);
        check("x_hold2", dut_out(), 4'b0100);

        // Exhaustive sweep of all operand pairs
        for (int i = 0; i < 16; i++) begin
            logic [3:0] ab;
            ab = 4'(i);
            apply(1'b1, 1'b1, ab[3:2], ab[1:0]);
            check($sformatf("sweep_a%0d_b%0d", ab[3:2], ab[1:0]), dut_out(), {m_valid, m_flags});
        end

        // Random stimulus with occasional resets and idle cycles
        for (int i = 0; i < 400; i++) begin
            logic r, v;
            r = ($urandom_range(0, 19) != 0);
            v = ($urandom_range(0, 9) < 7);
            apply(r, v, W'($urandom), W'($urandom));
            check($sformatf("rand%0d", i), dut_out(), {m_valid, m_flags});
        end

`ifdef COMPARATOR_2BIT_STATS_EN
        apply(1'b0, 1'b0, '0, '0);
        check_cnt("rst_lt", int'(lt_cnt), 0);
        check_cnt("rst_gt", int'(gt_cnt), 0);
        check_cnt("rst_eq", int'(eq_cnt), 0);
        for (int k = 1; k <= 5; k++) begin
            apply(1'b1, 1'b1, 2'd0, 2'd1);
            check_cnt($sformatf("lt_sat%0d", k), int'(lt_cnt), (k > 3) ? 3 : k);
        end
        check_cnt("gt_zero", int'(gt_cnt), 0);
        check_cnt("eq_zero", int'(eq_cnt), 0);
        stats_clr = 1'b1;
        apply(1'b1, 1'b1, 2'd1, 2'd1);
        stats_clr = 1'b0;
        check_cnt("clr_lt", int'(lt_cnt), 0);
        check_cnt("clr_gt", int'(gt_cnt), 0);
        check_cnt("clr_eq", int'(eq_cnt), 0);
        check("clr_flags", dut_out(), 4'b1001);
        apply(1'b1, 1'b1, 2'd2, 2'd1);
        check_cnt("gt_one", int'(gt_cnt), 1);
        check_cnt("eq_after", int'(eq_cnt), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
